// File: rtl/adder_pregen_stage_pkg.sv
// Shared widths and buffer state encodings for the prefix-adder front stage.
// Optional accepted-beat counter is enabled with ADDER_PREGEN_STATS_EN.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif
`ifndef ADDER_GP_BEAT_W
`define ADDER_GP_BEAT_W (3*`LEN_DATA + 1)
`endif

package adder_pregen_stage_pkg;

    localparam int unsigned LEN_DATA  = `LEN_DATA;
    // Packed beat layout is {cin, half_sum, p, g}.
    localparam int unsigned GP_BEAT_W = `ADDER_GP_BEAT_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/adder_pregen_stage_gp_skid_buffer.sv
// Generic two-entry valid/ready buffer (main + skid register) with registered
// in_ready/out_valid; outputs always come from the main register.
module gp_skid_buffer
    import adder_pregen_stage_pkg::*;
#(
    parameter int unsigned DW = GP_BEAT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          w_accept;
    logic          w_deliver;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_skid_to_main;

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_main = 1'b1;
                end else if (w_deliver) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_deliver) begin
                    w_state_nxt    = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake flags are decoded from the next state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

endmodule

// File: rtl/adder_pregen_stage.sv
// Front stage of the pipelined prefix adder: operand conditioning, per-bit g/p
// with carry-in folded into bit 0, buffered output. Optional: ADDER_PREGEN_STATS_EN.
module adder_pregen_stage
    import adder_pregen_stage_pkg::*;
#(
    parameter int unsigned W             = LEN_DATA,
    parameter int unsigned SKID_EN_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    input  logic         op_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] generate_out,
    output logic [W-1:0] propogate_out,
    output logic [W-1:0] half_sum_out,
`ifdef ADDER_PREGEN_STATS_EN
    output logic [31:0]  op_count,
`endif
    output logic         cin_out
);

    localparam int unsigned BEAT_W = 3 * W + 1;

    if (SKID_EN_DEPTH != 2) begin : g_depth_check
        $error("adder_pregen_stage: SKID_EN_DEPTH must be 2");
    end

    logic [W-1:0]      w_bx;
    logic              w_c;
    logic [W-1:0]      w_g;
    logic [W-1:0]      w_p;
    logic [W-1:0]      w_g_fold;
    logic [W-1:0]      w_p_fold;
    logic [BEAT_W-1:0] w_in_beat;
    logic [BEAT_W-1:0] w_out_beat;
    logic              w_in_ready;

    // Subtraction is A + ~B + 1; the +1 rides in through the carry fold.
    always_comb begin
        w_bx        = op_sub ? ~op_b : op_b;
        w_c         = op_sub | op_cin;
        w_g         = op_a & w_bx;
        w_p         = op_a ^ w_bx;
        w_g_fold    = w_g;
        w_p_fold    = w_p;
        w_g_fold[0] = w_g[0] | (w_p[0] & w_c);
        w_p_fold[0] = 1'b0;
    end

    assign w_in_beat = {w_c, w_p, w_p_fold, w_g_fold};

    gp_skid_buffer #(
        .DW (BEAT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_beat)
    );

    assign in_ready = w_in_ready;
    assign {cin_out, half_sum_out, propogate_out, generate_out} = w_out_beat;

`ifdef ADDER_PREGEN_STATS_EN
    logic [31:0] r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (in_valid && w_in_ready) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_adder_pregen_stage.sv
// Randomized/directed bench for adder_pregen_stage against an arithmetic model.
module tb_adder_pregen_stage;

    localparam int unsigned W = 32;
    localparam int unsigned BW = 3 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_sub;
    logic          op_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  generate_out;
    logic [W-1:0]  propogate_out;
    logic [W-1:0]  half_sum_out;
    logic          cin_out;
`ifdef ADDER_PREGEN_STATS_EN
    logic [31:0]   op_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] q_exp[$];
    logic [W-1:0]  q_sum[$];

    always #5 clk = ~clk;

    adder_pregen_stage #(.W(W), .SKID_EN_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_sub        (op_sub),
        .op_cin        (op_cin),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .generate_out  (generate_out),
        .propogate_out (propogate_out),
        .half_sum_out  (half_sum_out),
`ifdef ADDER_PREGEN_STATS_EN
        .op_count      (op_count),
`endif
        .cin_out       (cin_out)
    );

    // Expected beat {cin, half_sum, p_folded, g_folded} from the bitwise rules.
    function automatic logic [BW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub, input logic cin);
        logic [W-1:0] bx, g, p, gf, pf;
        logic c;
        bx = sub ? ~b : b;
        c  = sub | cin;
        g  = a & bx;
        p  = a ^ bx;
        gf = g;
        pf = p;
        gf[0] = g[0] | (p[0] & c);
        pf[0] = 1'b0;
        return {c, p, pf, gf};
    endfunction

    function automatic logic [W-1:0] arith_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sub, input logic cin);
        logic [W-1:0] bx;
        bx = sub ? ~b : b;
        return a + bx + W'(sub | cin);
    endfunction

    // Ripple the folded g/p to carries and form the sum the downstream stages would.
    function automatic logic [W-1:0] prefix_sum(input logic [BW-1:0] beat);
        logic [W-1:0] g, p, hs, s;
        logic c0, carry;
        {c0, hs, p, g} = beat;
        s[0]  = hs[0] ^ c0;
        carry = g[0];
        for (int i = 1; i < W; i++) begin
            s[i]  = hs[i] ^ carry;
            carry = g[i] | (p[i] & carry);
        end
        return s;
    endfunction

    // One clock of stimulus; returns what was observed and what the model expected.
    task automatic beat_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub, input logic cin, input logic ordy,
                              output logic acc, output logic dlv, output logic [BW-1:0] obs,
                              output logic [BW-1:0] exp_b, output logic [W-1:0] exp_s);
        @(negedge clk);
        obs   = {cin_out, half_sum_out, propogate_out, generate_out};
        acc   = v & in_ready;
        dlv   = out_valid & ordy;
        exp_b = 'x;
        exp_s = 'x;
        if (dlv && q_exp.size() != 0) begin
            exp_b = q_exp.pop_front();
            exp_s = q_sum.pop_front();
        end
        if (acc) begin
            q_exp.push_back(model(a, b, sub, cin));
            q_sum.push_back(arith_sum(a, b, sub, cin));
        end
        in_valid  = v;
        op_a      = a;
        op_b      = b;
        op_sub    = sub;
        op_cin    = cin;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0; op_cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_exp.delete();
        q_sum.delete();
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (generate_out !== '0) begin bad++; $display("FAIL reset_gen got=%h exp=0", generate_out); end
        total++; if (propogate_out !== '0) begin bad++; $display("FAIL reset_prop got=%h exp=0", propogate_out); end
        total++; if (half_sum_out !== '0) begin bad++; $display("FAIL reset_hsum got=%h exp=0", half_sum_out); end
        total++; if (cin_out !== 1'b0) begin bad++; $display("FAIL reset_cin got=%b exp=0", cin_out); end
`ifdef ADDER_PREGEN_STATS_EN
        total++; if (op_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", op_count); end
`endif
    endtask

    task automatic test_add();
        logic acc, dlv;
        logic [BW-1:0] obs, eb;
        logic [W-1:0] es;
        beat_cycle(1'b1, 32'h0000000F, 32'h00000001, 1'b0, 1'b0, 1'b1, acc, dlv, obs, eb, es);
        beat_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, dlv, obs, eb, es);
        total++; if (dlv !== 1'b1) begin bad++; $display("FAIL add_latency got_valid=%b exp=1", dlv); end
        total++;
        if (obs !== {1'b0, 32'h0000000E, 32'h0000000E, 32'h00000001}) begin
            bad++; $display("FAIL add_beat got=%h exp=%h", obs, {1'b0, 32'h0000000E, 32'h0000000E, 32'h00000001});
        end
        beat_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, dlv, obs, eb, es);
        total++; if (dlv !== 1'b0) begin bad++; $display("FAIL add_drained got_valid=%b exp=0", dlv); end
    endtask

    task automatic test_sub();
        logic acc, dlv;
        logic [BW-1:0] obs, eb;
        logic [W-1:0] es;
        for (int ci = 0; ci < 2; ci++) begin
            beat_cycle(1'b1, 32'd5, 32'd3, 1'b1, 1'(ci), 1'b1, acc, dlv, obs, eb, es);
            beat_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, dlv, obs, eb, es);
            total++;
            if (dlv !== 1'b1 || obs !== {1'b1, 32'hFFFFFFF9, 32'hFFFFFFF8, 32'h00000005}) begin
                bad++; $display("FAIL sub_beat_cin%0d valid=%b got=%h exp=%h", ci, dlv, obs,
                                {1'b1, 32'hFFFFFFF9, 32'hFFFFFFF8, 32'h00000005});
            end
            total++;
            if (prefix_sum(obs) !== 32'd2) begin
                bad++; $display("FAIL sub_sum_cin%0d got=%h exp=2", ci, prefix_sum(obs));
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc, dlv;
        logic [BW-1:0] obs, eb;
        logic [W-1:0] es;
        logic [W-1:0] a[3], b[3];
        logic [BW-1:0] exp_x;
        logic z_pending;
        int ndel;
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
        end
        exp_x = model(a[0], b[0], 1'b0, 1'b1);
        beat_cycle(1'b1, a[0], b[0], 1'b0, 1'b1, 1'b0, acc, dlv, obs, eb, es);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept_x got=%b exp=1", acc); end
        beat_cycle(1'b1, a[1], b[1], 1'b0, 1'b1, 1'b0, acc, dlv, obs, eb, es);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept_y got=%b exp=1", acc); end
        for (int k = 0; k < 3; k++) begin
            beat_cycle(1'b1, a[2], b[2], 1'b0, 1'b1, 1'b0, acc, dlv, obs, eb, es);
            total++; if (acc !== 1'b0 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_full_ready cyc%0d got=%b exp=0", k, in_ready);
            end
            total++; if (out_valid !== 1'b1 || obs !== exp_x) begin
                bad++; $display("FAIL bp_hold cyc%0d valid=%b got=%h exp=%h", k, out_valid, obs, exp_x);
            end
        end
        z_pending = 1'b1;
        ndel = 0;
        for (int k = 0; k < 10 && ndel < 3; k++) begin
            beat_cycle(z_pending, a[2], b[2], 1'b0, 1'b1, 1'b1, acc, dlv, obs, eb, es);
            if (acc) z_pending = 1'b0;
            if (dlv) begin
                total++;
                if (obs !== model(a[ndel], b[ndel], 1'b0, 1'b1) || obs !== eb) begin
                    bad++; $display("FAIL bp_order idx%0d got=%h exp=%h", ndel, obs,
                                    model(a[ndel], b[ndel], 1'b0, 1'b1));
                end
                ndel++;
            end
        end
        beat_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, dlv, obs, eb, es);
        total++; if (ndel != 3 || dlv !== 1'b0) begin
            bad++; $display("FAIL bp_count got=%0d extra=%b exp=3", ndel, dlv);
        end
    endtask

    task automatic test_stream();
        logic acc, dlv;
        logic [BW-1:0] obs, eb;
        logic [W-1:0] es;
        int nacc, ndel;
        test_reset();
        nacc = 0;
        ndel = 0;
        for (int k = 0; k < 100 + 6; k++) begin
            logic v;
            v = (k < 100);
            beat_cycle(v, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, acc, dlv, obs, eb, es);
            if (v) begin
                total++; if (acc !== 1'b1) begin bad++; $display("FAIL stream_ready cyc%0d got=%b exp=1", k, acc); end
                if (k > 0) begin
                    total++; if (dlv !== 1'b1) begin bad++; $display("FAIL stream_rate cyc%0d got=%b exp=1", k, dlv); end
                end
            end
            if (acc) nacc++;
            if (dlv) begin
                ndel++;
                total++; if (obs !== eb) begin bad++; $display("FAIL stream_beat n%0d got=%h exp=%h", ndel, obs, eb); end
                total++; if (prefix_sum(obs) !== es) begin
                    bad++; $display("FAIL stream_sum n%0d got=%h exp=%h", ndel, prefix_sum(obs), es);
                end
            end
        end
        total++; if (nacc != 100 || ndel != 100) begin
            bad++; $display("FAIL stream_count acc=%0d del=%0d exp=100", nacc, ndel);
        end
`ifdef ADDER_PREGEN_STATS_EN
        total++; if (op_count !== 32'd100) begin bad++; $display("FAIL stream_op_count got=%0d exp=100", op_count); end
`endif
    endtask

    task automatic test_reset_full();
        logic acc, dlv;
        logic [BW-1:0] obs, eb;
        logic [W-1:0] es;
        beat_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, acc, dlv, obs, eb, es);
        beat_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, acc, dlv, obs, eb, es);
        beat_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, dlv, obs, eb, es);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstfull_full got_ready=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rstfull_async valid=%b ready=%b exp=0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        q_exp.delete();
        q_sum.delete();
        for (int k = 0; k < 4; k++) begin
            beat_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, dlv, obs, eb, es);
            total++; if (dlv !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL rstfull_discard cyc%0d valid=%b ready=%b exp=0/1", k, dlv, in_ready);
            end
        end
`ifdef ADDER_PREGEN_STATS_EN
        total++; if (op_count !== 32'd0) begin bad++; $display("FAIL rstfull_count got=%0d exp=0", op_count); end
`endif
        total++; if (generate_out !== '0 || cin_out !== 1'b0) begin
            bad++; $display("FAIL rstfull_vectors g=%h c=%b exp=0", generate_out, cin_out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_stream();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
